i2c_eeprom_arbiter: RTL
=======================

Name: i2c_eeprom_arbiter

Overview:
- Shares the single I2C EEPROM byte controller between two requester ports (req0, req1) using round-robin arbitration.
- Per granted transaction: latches command, pulses i2c_start, waits for i2c_done or a timeout, returns status and read data.
- After every successful write, enforces the EEPROM internal write-cycle time (tWR) before the next grant.
- Sits between system masters (config loader, debug port) and the I2C byte controller.

Parameters:
DEV_ADDR, 7'h50, 7-bit EEPROM device address; wr_dev={DEV_ADDR,1'b0}, rd_dev={DEV_ADDR,1'b1}
TIMEOUT_CYCLES, 16384, max clk cycles in WAIT before declaring failure (controller NACK returns it to idle without i2c_done)
TWR_CYCLES, 250000, write-recovery hold-off after a successful write (5 ms at 50 MHz)

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  asynchronous active-low reset
req0 / req1  in  1  request; held high until the matching done pulse
we0 / we1  in  1  1=write, 0=read; sampled at grant
addr0 / addr1  in  16  EEPROM byte address; sampled at grant
wdata0 / wdata1  in  8  write data; sampled at grant
done0 / done1  out  1  one-cycle completion pulse to the granted requester
err  out  1  valid with doneN; 1=timeout (no i2c_done)
rdata  out  8  read byte; valid with doneN for reads, holds last value otherwise
busy  out  1  high in every state except IDLE
i2c_start  out  1  one-cycle start pulse to the controller
rd_flag  out  1  0=write, 1=read; stable from START until exit from WAIT
wr_dev / rd_dev  out  8  constant device bytes derived from DEV_ADDR
addh / addl  out  8  latched addr[15:8] / addr[7:0]
wr_data  out  8  latched write data
i2c_done  in  1  controller completion pulse
i2c_rdata  in  8  controller read byte; sampled when i2c_done=1

Behaviour:
- Reset values: done0=done1=err=i2c_start=rd_flag=busy=0; rdata=addh=addl=wr_data=0; state=IDLE; last_grant=1 (port 0 wins first contention); counters=0.
- States: IDLE, START, WAIT, RESP, RECOVER.
- IDLE:
  - If exactly one req is high, grant that port.
  - If both are high, grant the port != last_grant.
  - On grant: latch we/addr/wdata into rd_flag/addh/addl/wr_data, update last_grant, go to START.
- START: i2c_start=1 for this cycle only; clear timeout counter; go to WAIT.
- WAIT:
  - i2c_done=1: capture i2c_rdata into rdata if rd_flag=1; err_next=0; go to RESP.
  - Otherwise counter increments; when counter==TIMEOUT_CYCLES-1 with no i2c_done: err_next=1; go to RESP.
  - If i2c_done arrives in the same cycle as the terminal count, success wins.
- RESP (1 cycle):
  - doneN=1 for the granted port only; err=err_next.
  - Requests are ignored in this cycle, which gives the requester one edge to drop req.
  - Next state: RECOVER if write and err=0; otherwise IDLE.
- RECOVER: counter counts TWR_CYCLES cycles (0..TWR_CYCLES-1), then goes to IDLE. Pending requests wait; no grant during RECOVER.
- Latency: grant sampled in cycle T means i2c_start at T+1; i2c_done at cycle D means doneN at D+1.
- i2c_done outside WAIT is ignored (no state change, no pulse).
- A requester dropping req before done does not abort the transaction; done still pulses.
- Reset mid-operation returns all state and outputs to reset values immediately; no stop condition is generated (the controller is reset by the same rst_n).
- Counter width: ceil(log2(max(TIMEOUT_CYCLES, TWR_CYCLES))) bits; the counter is shared between WAIT and RECOVER.

Test Plan (bench parameters TIMEOUT_CYCLES=64, TWR_CYCLES=32, controller model):
1. req0 write, addr=16'h1234, wdata=8'hA5 -> at T+1: i2c_start pulse, addh=8'h12, addl=8'h34, wr_data=8'hA5, rd_flag=0; model done at D -> done0 at D+1, err=0; busy stays high 32 cycles after RESP.
2. req1 read, addr=16'h0010; model returns 8'h3C -> done1 pulse with rdata=8'h3C, err=0; IDLE immediately after RESP (no RECOVER).
3. req0 and req1 both asserted from reset, both reads -> port 0 served first, then port 1; repeat with both asserted -> port 0 again; no back-to-back grant to the same port while the other waits.
4. Model never asserts i2c_done -> done0 with err=1 exactly 64 cycles after WAIT entry; write with err=1 skips RECOVER.
5. req1 asserted during RECOVER after a port-0 write -> no i2c_start until RECOVER ends; grant to port 1 in the first IDLE cycle.
6. rst_n pulled low mid-WAIT -> all outputs return to reset values asynchronously; after release, first contention grants port 0; a stray i2c_done in IDLE produces no done pulse.

Source files
------------

// File: rtl/i2c_eeprom_arbiter.sv
// i2c_eeprom_arbiter: round-robin sharing of one I2C EEPROM byte controller between two
// requesters, with a controller timeout and an EEPROM write-cycle hold-off after good writes.
module i2c_eeprom_arbiter #(
   parameter logic [6:0] DEV_ADDR       = 7'h50,
   parameter int         TIMEOUT_CYCLES = 16384,
   parameter int         TWR_CYCLES     = 250000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_i,
   input  logic        req1_i,
   input  logic        we0_i,
   input  logic        we1_i,
   input  logic [15:0] addr0_i,
   input  logic [15:0] addr1_i,
   input  logic [7:0]  wdata0_i,
   input  logic [7:0]  wdata1_i,
   output logic        done0_o,
   output logic        done1_o,
   output logic        err_o,
   output logic [7:0]  rdata_o,
   output logic        busy_o,
   output logic        i2c_start_o,
   output logic        rd_flag_o,
   output logic [7:0]  wr_dev_o,
   output logic [7:0]  rd_dev_o,
   output logic [7:0]  addh_o,
   output logic [7:0]  addl_o,
   output logic [7:0]  wr_data_o,
   input  logic        i2c_done_i,
   input  logic [7:0]  i2c_rdata_i
);

   // One counter serves both the WAIT timeout and the RECOVER hold-off, so size it for the larger.
   localparam int MAX_CYCLES = (TIMEOUT_CYCLES > TWR_CYCLES) ? TIMEOUT_CYCLES : TWR_CYCLES;
   localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TWR_LAST = CNT_W'(TWR_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_RESP, S_RECOVER} state_t;

   state_t           state_q;
   logic             last_grant_q;
   logic             gnt_port_q;
   logic [CNT_W-1:0] cnt_q;
   logic             done0_q, done1_q, err_q, busy_q, i2c_start_q, rd_flag_q;
   logic [7:0]       rdata_q, addh_q, addl_q, wr_data_q;

   logic             gnt_vld_d;
   logic             gnt_port_d;
   logic             sel_we_d;
   logic [15:0]      sel_addr_d;
   logic [7:0]       sel_wdata_d;

   // Round-robin choice: a lone request wins outright, contention goes to the port not served last.
   always_comb begin
      gnt_vld_d  = req0_i | req1_i;
      gnt_port_d = 1'b0;
      if (req0_i && req1_i) begin
         gnt_port_d = ~last_grant_q;
      end else if (req1_i) begin
         gnt_port_d = 1'b1;
      end
      sel_we_d    = gnt_port_d ? we1_i    : we0_i;
      sel_addr_d  = gnt_port_d ? addr1_i  : addr0_i;
      sel_wdata_d = gnt_port_d ? wdata1_i : wdata0_i;
   end

   // Transaction sequencer: grant, start pulse, wait/timeout, response pulse, write recovery.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         gnt_port_q   <= 1'b0;
         cnt_q        <= '0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
         i2c_start_q  <= 1'b0;
         rd_flag_q    <= 1'b0;
         rdata_q      <= 8'h00;
         addh_q       <= 8'h00;
         addl_q       <= 8'h00;
         wr_data_q    <= 8'h00;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (gnt_vld_d) begin
                  state_q      <= S_START;
                  busy_q       <= 1'b1;
                  i2c_start_q  <= 1'b1;
                  gnt_port_q   <= gnt_port_d;
                  last_grant_q <= gnt_port_d;
                  rd_flag_q    <= ~sel_we_d;
                  addh_q       <= sel_addr_d[15:8];
                  addl_q       <= sel_addr_d[7:0];
                  wr_data_q    <= sel_wdata_d;
               end
            end
            S_START: begin
               i2c_start_q <= 1'b0;
               cnt_q       <= '0;
               state_q     <= S_WAIT;
            end
            S_WAIT: begin
               // A completion on the terminal-count cycle still counts as success.
               if (i2c_done_i) begin
                  if (rd_flag_q) begin
                     rdata_q <= i2c_rdata_i;
                  end
                  err_q   <= 1'b0;
                  done0_q <= ~gnt_port_q;
                  done1_q <= gnt_port_q;
                  state_q <= S_RESP;
               end else if (cnt_q == TO_LAST) begin
                  err_q   <= 1'b1;
                  done0_q <= ~gnt_port_q;
                  done1_q <= gnt_port_q;
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_RESP: begin
               // Requests are not looked at here, giving the requester one edge to drop req.
               done0_q <= 1'b0;
               done1_q <= 1'b0;
               cnt_q   <= '0;
               if (!rd_flag_q && !err_q) begin
                  state_q <= S_RECOVER;
               end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            S_RECOVER: begin
               if (cnt_q == TWR_LAST) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q     <= S_IDLE;
               busy_q      <= 1'b0;
               i2c_start_q <= 1'b0;
            end
         endcase
      end
   end

   assign done0_o     = done0_q;
   assign done1_o     = done1_q;
   assign err_o       = err_q;
   assign rdata_o     = rdata_q;
   assign busy_o      = busy_q;
   assign i2c_start_o = i2c_start_q;
   assign rd_flag_o   = rd_flag_q;
   assign wr_dev_o    = {DEV_ADDR, 1'b0};
   assign rd_dev_o    = {DEV_ADDR, 1'b1};
   assign addh_o      = addh_q;
   assign addl_o      = addl_q;
   assign wr_data_o   = wr_data_q;

endmodule
